dec_to_bin_seq: RTL and testbench
=================================

DEC_TO_BIN_SEQ -- requirements
Module: dec_to_bin_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  conversion request, sampled in IDLE only
- digit_6..digit_1  input  4 each  BCD digits, digit_6 most significant, sampled at accept
- busy  output  1  high while converting
- done  output  1  one-cycle completion pulse
- err  output  1  invalid-digit flag
- bin_20  output  20  binary result, 0..999999
REQ-003 The block SHALL have no parameters; widths SHALL be fixed at 6 digits in and 20 bits out.

Function
REQ-004 The block SHALL use reverse double dabble: a 44-bit shift register {bcd[23:0], bin[19:0]}, one iteration per clock.
REQ-005 Each iteration SHALL shift the whole register right by 1, then subtract 3 from each BCD nibble whose post-shift value is >= 8, all six nibbles in the same cycle.
REQ-006 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-007 In IDLE with start=1 (accept edge):
- bcd SHALL load {digit_6..digit_1}
- bin SHALL clear to 0
- the iteration counter SHALL clear
- state SHALL go to SHIFT
REQ-008 SHIFT SHALL last exactly 20 cycles, then go to DONE.
REQ-009 DONE SHALL last exactly 1 cycle, then return to IDLE unconditionally.
REQ-010 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE.
REQ-011 The accept-to-done latency SHALL be 21 cycles: done is high in the 21st cycle after the accept edge.
REQ-012 bin_20 SHALL update only on entry to DONE and SHALL hold its value until the next DONE or reset.
REQ-013 start SHALL be ignored in SHIFT and DONE; there SHALL be no queuing.
REQ-014 Digit inputs SHALL be sampled only at the accept edge; later input changes SHALL NOT affect the result in progress.
REQ-015 err SHALL update only on entry to DONE and SHALL hold until the next DONE or reset.

Reset
REQ-016 On rst=1 the block SHALL immediately enter IDLE, independent of clk, with:
- busy=0, done=0, err=0, bin_20=0
- shift register and counter cleared
REQ-017 Reset asserted mid-SHIFT SHALL abort the conversion with no done pulse; the first accept after rst deasserts SHALL behave as REQ-007.

Configuration
REQ-018 With macro DEC_TO_BIN_DIGIT_CHECK_EN defined, an accept with any digit > 9 SHALL:
- skip SHIFT and go directly to DONE on the next edge (latency 1)
- set err=1 and bin_20=0
A valid accept SHALL set err=0.
REQ-019 Without DEC_TO_BIN_DIGIT_CHECK_EN:
- err SHALL be constant 0
- every accept SHALL take the 21-cycle path
- bin_20 for digits > 9 is unspecified; only its timing is defined

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- digits 0,0,0,0,0,0 + start -> 21 cycles later done=1, bin_20=0x00000, err=0; busy high for exactly 20 cycles.
- digits 9,9,9,9,9,9 -> bin_20=0xF423F (999999); digits 2,6,2,1,4,3 -> bin_20=0x3FFFF (262143).
- digits 0,0,0,0,1,0 accepted, start held high and digits changed to 5,5,5,5,5,5 during SHIFT -> single done pulse, bin_20=10, next accept only after IDLE.
- rst pulsed after the 7th SHIFT cycle of 1,2,3,4,5,6 -> outputs zero immediately, no done pulse; a new accept of 1,2,3,4,5,6 -> bin_20=0x1E240.
- With DEC_TO_BIN_DIGIT_CHECK_EN: digits 0,0,0,0,0xA,0 -> done on the next cycle, err=1, bin_20=0; a following valid 0,0,0,0,0,7 -> err=0, bin_20=7.
- Without DEC_TO_BIN_DIGIT_CHECK_EN: the same invalid input -> done after 21 cycles, err=0.

Source files
------------

// File: rtl/dec_to_bin_seq.sv
// ---------------------------------------------------------------------------
// dec_to_bin_seq
//
// Converts a six-digit BCD number (000000..999999) to a 20-bit binary value
// using reverse double dabble. The 44-bit register {bcd[23:0], bin[19:0]}
// moves one bit per clock. A valid conversion takes 20 SHIFT cycles and then
// one DONE cycle, so done is high in the 21st cycle after the accept edge.
//
// Optional feature (macro DEC_TO_BIN_DIGIT_CHECK_EN):
//   When this macro is defined, an accept with any digit > 9 skips SHIFT and
//   enters DONE on the next edge with err=1 and bin_20=0. A valid accept
//   clears err. When the macro is undefined, err is constantly 0 and every
//   accept takes the 20-cycle SHIFT path.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   start             conversion request, sampled in IDLE only
//   digit_6..digit_1  BCD digits, digit_6 most significant, sampled at accept
//   busy              high while in SHIFT
//   done              one-cycle completion pulse (DONE state)
//   err               invalid-digit flag, updated on entry to DONE
//   bin_20            binary result, updated on entry to DONE
// ---------------------------------------------------------------------------
module dec_to_bin_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  digit_6,
   input  logic [3:0]  digit_5,
   input  logic [3:0]  digit_4,
   input  logic [3:0]  digit_3,
   input  logic [3:0]  digit_2,
   input  logic [3:0]  digit_1,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [19:0] bin_20
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [43:0] sr;
   logic [43:0] sr_step;
   logic [4:0]  cnt;
   logic [23:0] digits_in;
   logic        last_iter;
   logic        bad_digit;

   // One reverse-double-dabble iteration: shift the whole register right,
   // then pull every BCD nibble that reached 8 or more back down by 3.
   function automatic logic [43:0] dabble_step(input logic [43:0] v);
      logic [43:0] s;
      s = v >> 1;
      for (int i = 0; i < 6; i++) begin
         if (s[20 + 4*i +: 4] >= 4'd8)
            s[20 + 4*i +: 4] = s[20 + 4*i +: 4] - 4'd3;
      end
      return s;
   endfunction

   function automatic logic any_nibble_above_9(input logic [23:0] d);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (d[4*i +: 4] > 4'd9)
            bad = 1'b1;
      end
      return bad;
   endfunction

   assign digits_in = {digit_6, digit_5, digit_4, digit_3, digit_2, digit_1};
   assign sr_step   = dabble_step(sr);
   // cnt counts completed iterations; the 20th happens while cnt == 19.
   assign last_iter = (cnt == 5'd19);

`ifdef DEC_TO_BIN_DIGIT_CHECK_EN
   assign bad_digit = any_nibble_above_9(digits_in);
`else
   assign bad_digit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = bad_digit ? DONE : SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_iter)
               state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: shift register, iteration counter and held result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr     <= '0;
         cnt    <= '0;
         bin_20 <= '0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sr  <= {digits_in, 20'd0};
                  cnt <= '0;
                  // Invalid digits go straight to DONE, so the result
                  // registers must be loaded on this same edge.
                  if (bad_digit) begin
                     bin_20 <= '0;
                     err    <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               sr  <= sr_step;
               cnt <= cnt + 5'd1;
               if (last_iter) begin
                  bin_20 <= sr_step[19:0];
                  err    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dec_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_dec_to_bin_seq
//
// Self-checking bench for dec_to_bin_seq. Expected results come from the
// decimal value of the digits (plain weighted sum), expected timing from the
// cycle budget of the conversion. Directed cases plus random valid numbers.
// Builds with or without DEC_TO_BIN_DIGIT_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_dec_to_bin_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  digit_6, digit_5, digit_4, digit_3, digit_2, digit_1;
   logic        busy;
   logic        done;
   logic        err;
   logic [19:0] bin_20;

   int n_assert;
   int n_fail;

   // Model of the held outputs between conversions
   logic [19:0] prev_bin;
   logic        prev_bin_known;
   logic        prev_err;

   dec_to_bin_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .digit_6 (digit_6),
      .digit_5 (digit_5),
      .digit_4 (digit_4),
      .digit_3 (digit_3),
      .digit_2 (digit_2),
      .digit_1 (digit_1),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .bin_20  (bin_20)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_digits(input logic [23:0] d);
      {digit_6, digit_5, digit_4, digit_3, digit_2, digit_1} = d;
   endtask

   function automatic int bcd_value(input logic [23:0] d);
      int v;
      v = 0;
      for (int i = 5; i >= 0; i--) begin
         logic [3:0] n;
         n = d[4*i +: 4];
         v = v * 10 + int'(n);
      end
      return v;
   endfunction

   function automatic bit has_invalid(input logic [23:0] d);
      bit b;
      b = 1'b0;
      for (int i = 0; i < 6; i++) begin
         logic [3:0] n;
         n = d[4*i +: 4];
         if (n > 4'd9) b = 1'b1;
      end
      return b;
   endfunction

   // Runs one conversion. hold_start keeps start high through SHIFT/DONE;
   // scramble changes the digit inputs right after the accept edge.
   task automatic convert(input string name, input logic [23:0] d,
                          input bit hold_start, input bit scramble);
      int  lat;
      int  busy_cycles;
      bit  invalid;
      bit  early;
      logic [19:0] exp_bin;
      invalid = has_invalid(d);
      early   = 1'b0;
`ifdef DEC_TO_BIN_DIGIT_CHECK_EN
      early   = invalid;
`endif
      lat = early ? 1 : 21;
      exp_bin = early ? 20'd0 : 20'(bcd_value(d));

      @(negedge clk);
      set_digits(d);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold_start) start = 1'b0;
      if (scramble) set_digits(24'h555555);

      busy_cycles = 0;
      for (int c = 1; c <= lat; c++) begin
         if (busy) busy_cycles++;
         chk({name, ".done_timing"}, 32'(done), 32'(c == lat));
         if (c < lat) begin
            if (prev_bin_known) chk({name, ".bin_hold"}, 32'(bin_20), 32'(prev_bin));
            chk({name, ".err_hold"}, 32'(err), 32'(prev_err));
            @(posedge clk);
            #1;
         end
      end
      chk({name, ".busy_cycles"}, 32'(busy_cycles), 32'(lat - 1));
      if (!(invalid && !early)) chk({name, ".bin"}, 32'(bin_20), 32'(exp_bin));
      chk({name, ".err"}, 32'(err), 32'(early));

      prev_bin       = bin_20;
      prev_bin_known = !(invalid && !early);
      if (prev_bin_known) prev_bin = exp_bin;
      prev_err       = early;

      // Back in IDLE: no second done, not busy even with start still high.
      @(posedge clk);
      #1;
      chk({name, ".idle_busy"}, 32'(busy), 32'd0);
      chk({name, ".idle_done"}, 32'(done), 32'd0);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk({name, ".no_requeue"}, 32'(busy | done), 32'd0);
   endtask

   initial begin
      logic [23:0] rd;
      int          dones;
      n_assert       = 0;
      n_fail         = 0;
      prev_bin       = '0;
      prev_bin_known = 1'b1;
      prev_err       = 1'b0;
      start          = 1'b0;
      set_digits(24'h000000);

      // Reset state
      rst = 1'b1;
      #1;
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.done", 32'(done), 32'd0);
      chk("reset.err",  32'(err),  32'd0);
      chk("reset.bin",  32'(bin_20), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      convert("zero",   24'h000000, 1'b0, 1'b0);
      convert("max",    24'h999999, 1'b0, 1'b0);
      convert("p262143",24'h262143, 1'b0, 1'b0);
      convert("hold10", 24'h000010, 1'b1, 1'b1);

      // Reset in the middle of SHIFT aborts the conversion
      @(negedge clk);
      set_digits(24'h123456);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("abort.busy_before", 32'(busy), 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      chk("abort.err",  32'(err),  32'd0);
      chk("abort.bin",  32'(bin_20), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk);
         #1;
         if (done || busy) dones++;
      end
      chk("abort.no_done", 32'(dones), 32'd0);
      prev_bin = '0;
      prev_bin_known = 1'b1;
      prev_err = 1'b0;
      convert("after_abort", 24'h123456, 1'b0, 1'b0);

      // Invalid digit handling (both builds)
      convert("invalid", 24'h0000A0, 1'b0, 1'b0);
      convert("valid7",  24'h000007, 1'b0, 1'b0);

      // Random valid numbers
      for (int k = 0; k < 8; k++) begin
         rd = '0;
         for (int i = 0; i < 6; i++) rd[4*i +: 4] = 4'($urandom_range(0, 9));
         convert("random", rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
